// File: rtl/mc_pkg.sv
// Shared constants and types for the serial-slave register-file memory.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mc_pkg;
   localparam int ADDR_W      = 7;
   localparam int DATA_W      = 8;
   localparam int DEPTH       = 128;
   localparam int SYNC_STAGES = 2;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] data_t;

   typedef enum logic [2:0] {
      IDLE, ADDR, A_ACK, WR, D_ACK, RD, M_ACK
   } mc_state_t;
endpackage

// File: rtl/memory_controller_if.sv
// Serial bus bundle between the bus master and the memory slave.
// Latency: wires only.
// Backpressure: none; SCL pacing by the master is the only flow control.
// Signals: scl/sda_in from master, sda_oe/ack/data_out from slave.
interface memory_controller_if;
   import mc_pkg::*;

   logic  scl;
   logic  sda_in;
   logic  sda_oe;
   logic  ack;
   data_t data_out;

   modport master (output scl, sda_in, input sda_oe, ack, data_out);
   modport slave  (input scl, sda_in, output sda_oe, ack, data_out);
endinterface

// File: rtl/mc_sync_edge.sv
// Synchronizes one asynchronous pin and flags its rising/falling edges.
// Latency: level valid STAGES clks after pin change; edge pulses in the same cycle.
// Backpressure: none.
// Ports: clk, rst (async active-low), din (async pin), level/rise/fall (clk domain).
module mc_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);
   logic [STAGES-1:0] sync_q, sync_d;
   logic              prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], din};
      prev_d = sync_q[STAGES-1];
   end

   // Reset to the idle-bus level (high) so release of reset raises no edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign level = sync_q[STAGES-1];
   assign rise  = level & ~prev_q;
   assign fall  = ~level & prev_q;
endmodule

// File: rtl/memory_controller.sv
// I2C-style serial slave fronting a 128x8 register file; answers every frame.
// Latency: bus events act SYNC_STAGES+1 clks after the pin change; write commit one clk after bit 8.
// Backpressure: none; master must hold each SCL level >= SYNC_STAGES+2 clks.
// Ports: clk, rst (async active-low), bus (slave modport: scl, sda_in, sda_oe, ack, data_out).
module memory_controller
   import mc_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   memory_controller_if.slave  bus
);
   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;
   logic start_evt, stop_evt;

   mc_sync_edge #(.STAGES(SYNC_STAGES)) u_scl (
      .clk(clk), .rst(rst), .din(bus.scl),
      .level(scl_lvl), .rise(scl_rise), .fall(scl_fall));
   mc_sync_edge #(.STAGES(SYNC_STAGES)) u_sda (
      .clk(clk), .rst(rst), .din(bus.sda_in),
      .level(sda_lvl), .rise(sda_rise), .fall(sda_fall));

   assign start_evt = sda_fall & scl_lvl;
   assign stop_evt  = sda_rise & scl_lvl;

   mc_state_t   state_q, state_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   data_t       shift_q, shift_d;
   addr_t       addr_q, addr_d;
   logic        rw_q, rw_d;
   // Bit 8 seen (ADDR/WR/RD) or master ACK seen (M_ACK); consumed on the next SCL fall.
   logic        byte_done_q, byte_done_d;
   logic        commit_q, commit_d;
   logic        sda_oe_q, sda_oe_d;
   data_t       data_out_q, data_out_d;
   data_t       mem_q [DEPTH];
   data_t       mem_rd;
   logic        ack_o;

   assign mem_rd = mem_q[addr_q];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // START/STOP take priority over any SCL edge in the same cycle.
   always_comb begin
      state_d = state_q;
      if (stop_evt)       state_d = IDLE;
      else if (start_evt) state_d = ADDR;
      else begin
         unique case (state_q)
            ADDR:    if (scl_fall && byte_done_q) state_d = A_ACK;
            A_ACK:   if (scl_fall) state_d = rw_q ? RD : WR;
            WR:      if (scl_fall && byte_done_q) state_d = D_ACK;
            D_ACK:   if (scl_fall) state_d = WR;
            RD:      if (scl_fall && byte_done_q) state_d = M_ACK;
            M_ACK: begin
               if (scl_rise && sda_lvl)          state_d = IDLE;
               else if (scl_fall && byte_done_q) state_d = RD;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      addr_d      = addr_q;
      rw_d        = rw_q;
      byte_done_d = byte_done_q;
      commit_d    = 1'b0;
      sda_oe_d    = sda_oe_q;
      data_out_d  = data_out_q;
      if (commit_q) data_out_d = shift_q;

      if (stop_evt || start_evt) begin
         bit_cnt_d   = '0;
         byte_done_d = 1'b0;
         sda_oe_d    = 1'b0;
      end else begin
         unique case (state_q)
            ADDR, WR: begin
               if (scl_rise && !byte_done_q) begin
                  shift_d   = {shift_q[DATA_W-2:0], sda_lvl};
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'(DATA_W-1)) begin
                     byte_done_d = 1'b1;
                     commit_d    = (state_q == WR);
                  end
               end else if (scl_fall && byte_done_q) begin
                  byte_done_d = 1'b0;
                  sda_oe_d    = 1'b1;
                  if (state_q == ADDR) begin
                     addr_d = shift_q[DATA_W-1:1];
                     rw_d   = shift_q[0];
                  end
               end
            end
            A_ACK: begin
               if (scl_fall) begin
                  bit_cnt_d = '0;
                  sda_oe_d  = 1'b0;
                  if (rw_q) begin
                     shift_d    = mem_rd;
                     data_out_d = mem_rd;
                     sda_oe_d   = ~mem_rd[DATA_W-1];
                  end
               end
            end
            D_ACK: begin
               if (scl_fall) begin
                  bit_cnt_d = '0;
                  sda_oe_d  = 1'b0;
                  addr_d    = addr_q + 1'b1;
               end
            end
            RD: begin
               // Master samples on the rise; the next bit is put out on the fall.
               if (scl_rise && !byte_done_q) begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'(DATA_W-1)) byte_done_d = 1'b1;
               end else if (scl_fall) begin
                  if (byte_done_q) begin
                     byte_done_d = 1'b0;
                     sda_oe_d    = 1'b0;
                  end else begin
                     shift_d  = {shift_q[DATA_W-2:0], 1'b0};
                     sda_oe_d = ~shift_q[DATA_W-2];
                  end
               end
            end
            M_ACK: begin
               if (scl_rise && !sda_lvl) begin
                  addr_d      = addr_q + 1'b1;
                  byte_done_d = 1'b1;
               end else if (scl_fall && byte_done_q) begin
                  byte_done_d = 1'b0;
                  bit_cnt_d   = '0;
                  shift_d     = mem_rd;
                  data_out_d  = mem_rd;
                  sda_oe_d    = ~mem_rd[DATA_W-1];
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         addr_q      <= '0;
         rw_q        <= 1'b0;
         byte_done_q <= 1'b0;
         commit_q    <= 1'b0;
         sda_oe_q    <= 1'b0;
         data_out_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         addr_q      <= addr_d;
         rw_q        <= rw_d;
         byte_done_q <= byte_done_d;
         commit_q    <= commit_d;
         sda_oe_q    <= sda_oe_d;
         data_out_q  <= data_out_d;
         if (commit_q) mem_q[addr_q] <= shift_q;
      end
   end

   // ack mirrors the pull-down only in ACK slots, never for read data bits.
   always_comb begin
      ack_o = 1'b0;
      if (state_q == A_ACK || state_q == D_ACK) ack_o = sda_oe_q;
   end

   assign bus.ack      = ack_o;
   assign bus.sda_oe   = sda_oe_q;
   assign bus.data_out = data_out_q;
endmodule

// File: tb/tb_memory_controller.sv
// Bench for memory_controller: bit-banged master, reference memory model, scoreboard.
module tb_memory_controller;
   import mc_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic sda_m;
   int   checks   = 0;
   int   failures = 0;
   logic [31:0] sb_q [$];
   logic [7:0]  model_mem [128];
   logic [7:0]  exp_dout;
   logic [6:0]  cur_addr;

   memory_controller_if bus();
   assign bus.sda_in = sda_m & ~bus.sda_oe;

   memory_controller dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic wclk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic sb_chk(input string tag, input logic [31:0] got);
      logic [31:0] exp;
      exp = (sb_q.size() != 0) ? sb_q.pop_front() : 32'hFFFF_FFFF;
      chk(tag, got, exp);
   endtask

   task automatic tx_bit(input logic b);
      wclk(4); sda_m = b; wclk(4); bus.scl = 1'b1; wclk(8); bus.scl = 1'b0;
   endtask

   task automatic rx_bit(output logic b, output logic a);
      wclk(4); sda_m = 1'b1; wclk(4); bus.scl = 1'b1; wclk(6);
      b = bus.sda_in; a = bus.ack;
      wclk(2); bus.scl = 1'b0;
   endtask

   task automatic start_cond();
      sda_m = 1'b1; wclk(4); bus.scl = 1'b1; wclk(8);
      sda_m = 1'b0; wclk(8); bus.scl = 1'b0;
   endtask

   task automatic stop_cond();
      wclk(4); sda_m = 1'b0; wclk(4); bus.scl = 1'b1; wclk(8);
      sda_m = 1'b1; wclk(8);
   endtask

   // Sends a byte, then expects the slave to ACK: {ack, sda} = 2'b10 in the slot.
   task automatic send_byte(input logic [7:0] b, input string tag);
      logic sd, a;
      sb_q.push_back(32'h2);
      for (int i = 7; i >= 0; i--) tx_bit(b[i]);
      rx_bit(sd, a);
      sb_chk(tag, {30'd0, a, sd});
   endtask

   task automatic addr_phase(input logic [6:0] addr, input logic rw);
      start_cond();
      send_byte({addr, rw}, rw ? "addr_ack_rd" : "addr_ack_wr");
      cur_addr = addr;
   endtask

   task automatic wr_byte(input logic [7:0] b);
      send_byte(b, "data_ack");
      model_mem[cur_addr] = b;
      exp_dout = b;
      cur_addr = cur_addr + 7'd1;
   endtask

   task automatic rd_byte(input logic nack);
      logic [7:0] val;
      logic sd, a, ack_seen;
      sb_q.push_back({24'd0, model_mem[cur_addr]});
      exp_dout = model_mem[cur_addr];
      ack_seen = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         rx_bit(sd, a);
         val[i] = sd;
         ack_seen |= a;
      end
      sb_chk("rd_byte", {24'd0, val});
      chk("rd_no_ack", {31'd0, ack_seen}, 32'd0);
      tx_bit(nack);
      if (!nack) cur_addr = cur_addr + 7'd1;
   endtask

   task automatic mem_all(input string tag);
      int nbad;
      nbad = 0;
      for (int i = 0; i < 128; i++) if (dut.mem_q[i] !== model_mem[i]) nbad++;
      chk(tag, nbad, 32'd0);
   endtask

   task automatic chk_idle(input string tag);
      chk(tag, {29'd0, dut.state_q}, {29'd0, IDLE});
   endtask

   initial begin
      rst = 1'b0; sda_m = 1'b1; bus.scl = 1'b1;
      exp_dout = 8'h00; cur_addr = '0;
      for (int i = 0; i < 128; i++) model_mem[i] = 8'h00;
      wclk(5);
      chk("rst_sda_oe", {31'd0, bus.sda_oe}, 32'd0);
      chk("rst_ack", {31'd0, bus.ack}, 32'd0);
      chk("rst_dout", {24'd0, bus.data_out}, 32'd0);
      rst = 1'b1;
      wclk(5);

      // Dirty a word, then reset in the middle of a data byte.
      addr_phase(7'h03, 1'b0);
      wr_byte(8'h5A);
      stop_cond();
      chk("pre_rst_mem3", {24'd0, dut.mem_q[3]}, {24'd0, model_mem[3]});
      addr_phase(7'h10, 1'b0);
      tx_bit(1'b1); tx_bit(1'b0); tx_bit(1'b1); tx_bit(1'b1);
      rst = 1'b0;
      for (int i = 0; i < 128; i++) model_mem[i] = 8'h00;
      exp_dout = 8'h00;
      wclk(5);
      chk("midrst_sda_oe", {31'd0, bus.sda_oe}, 32'd0);
      chk("midrst_ack", {31'd0, bus.ack}, 32'd0);
      chk("midrst_dout", {24'd0, bus.data_out}, 32'd0);
      chk_idle("midrst_state");
      mem_all("midrst_mem_clear");
      bus.scl = 1'b1; sda_m = 1'b1;
      wclk(2);
      rst = 1'b1;
      wclk(5);

      // Write 0xAB to 0x55.
      addr_phase(7'h55, 1'b0);
      wr_byte(8'hAB);
      stop_cond();
      chk("wr_mem55", {24'd0, dut.mem_q[7'h55]}, {24'd0, model_mem[7'h55]});
      chk("wr_dout", {24'd0, bus.data_out}, {24'd0, exp_dout});

      // Read it back, master NACKs.
      addr_phase(7'h55, 1'b1);
      rd_byte(1'b1);
      wclk(2);
      chk_idle("nack_state");
      chk("nack_sda_oe", {31'd0, bus.sda_oe}, 32'd0);
      stop_cond();
      chk("rd_dout", {24'd0, bus.data_out}, {24'd0, exp_dout});

      // Burst write across the top of memory, then burst read across it.
      addr_phase(7'h7F, 1'b0);
      wr_byte(8'h11);
      wr_byte(8'h22);
      stop_cond();
      chk("wrap_mem7f", {24'd0, dut.mem_q[7'h7F]}, {24'd0, model_mem[7'h7F]});
      chk("wrap_mem00", {24'd0, dut.mem_q[0]}, {24'd0, model_mem[0]});
      addr_phase(7'h7F, 1'b1);
      rd_byte(1'b0);
      rd_byte(1'b1);
      stop_cond();
      chk("wrap_rd_dout", {24'd0, bus.data_out}, {24'd0, exp_dout});

      // STOP after half a data byte: nothing written.
      addr_phase(7'h10, 1'b0);
      tx_bit(1'b1); tx_bit(1'b1); tx_bit(1'b1); tx_bit(1'b1);
      stop_cond();
      chk("partial_mem10", {24'd0, dut.mem_q[7'h10]}, {24'd0, model_mem[7'h10]});
      chk_idle("partial_state");
      chk("partial_ack", {31'd0, bus.ack}, 32'd0);
      chk("partial_dout", {24'd0, bus.data_out}, {24'd0, exp_dout});

      // Repeated START right after a write address ACK, then read.
      addr_phase(7'h55, 1'b0);
      addr_phase(7'h55, 1'b1);
      rd_byte(1'b1);
      stop_cond();
      chk("rs_dout", {24'd0, bus.data_out}, {24'd0, exp_dout});
      mem_all("final_mem");
      chk("sb_drained", sb_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
